arb_rr16: RTL and testbench
===========================

Name: arb_rr16

Overview:
- 16-requester round-robin arbiter that shares one downstream resource among up to 16 clients.
- Produces a one-hot grant plus its 4-bit binary index, using the same encoding as the team's 16-to-4 encoder (bit k maps to index k).
- Sits between the request sources and the shared resource. The registered index drives the resource's select/mux.

Parameters:
- MAX_HOLD, 255, maximum consecutive GRANT cycles before forced release. Used only with ARB_TIMEOUT_EN; range 1..65535.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  arbitration enable; when 0, no new grant is issued
- req  input  16  request vector, bit k = requester k, level-sensitive
- done  input  1  release strobe from the current owner/resource, sampled each cycle
- gnt  output  16  registered one-hot grant, all-zero when idle
- gnt_idx  output  4  registered binary index of the granted requester
- gnt_valid  output  1  high while any grant is held
- timeout  output  1  one-cycle pulse on forced release; constant 0 when the feature is absent

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, ptr=0, gnt=16'h0000, gnt_idx=4'h0, gnt_valid=0, timeout=0, hold counter=0.
  - Asserting rst mid-grant drops the grant immediately, without waiting for a clock edge.
- State IDLE:
  - If en=1 and req!=0 at a rising edge, pick the first set bit scanning ptr, ptr+1, ..., 15, 0, ..., ptr-1 (wraps 15->0).
  - At that same edge: gnt=one-hot(winner), gnt_idx=winner, gnt_valid=1, state=GRANT.
  - Latency: request sampled at edge N, grant visible immediately after edge N.
  - If en=0 or req=0: remain in IDLE, outputs stay zero.
- State GRANT:
  - gnt, gnt_idx and gnt_valid hold stable.
  - Release condition at an edge: done=1, OR req[gnt_idx]=0 (requester withdrew).
  - On release: gnt=0, gnt_idx=0, gnt_valid=0, ptr=(gnt_idx+1) mod 16 (4-bit wrap, 15->0), state=IDLE.
  - Other req bits changing during GRANT have no effect.
  - en=0 during GRANT does not revoke the current grant. It only blocks the next arbitration.
- Gap between grants: exactly one idle cycle (gnt_valid=0) always separates two consecutive grants, including back-to-back re-grant to the same requester.
- done while in IDLE is ignored.
- Fairness:
  - A requester holding req high is granted within 15 grants of any other requesters.
  - After requester k is served, it has the lowest priority.
- gnt_idx always equals the encoder output of gnt. gnt is never multi-hot.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit hold counter clears on entering GRANT and increments each GRANT cycle.
  - When it reaches MAX_HOLD without a normal release, the arbiter forces a release at that edge: same update as a normal release, with ptr advanced past the owner.
  - timeout pulses 1 for exactly one cycle, coincident with the first IDLE cycle.
  - If done=1 on the same edge the counter reaches MAX_HOLD, it is a normal release and timeout stays 0.
- Not defined: no counter is built, timeout is tied 0, and a grant is held indefinitely until done or withdrawal.

Test Plan:
- Reset/idle: rst=1 with req=16'hFFFF -> gnt=0, gnt_idx=0, gnt_valid=0. Release rst, en=1 -> next edge gnt=16'h0001, gnt_idx=0.
- Round robin: req=16'hFFFF held, done pulsed 1 cycle after each grant -> gnt_idx sequence 0,1,2,...,15,0, with one gnt_valid=0 cycle between each grant.
- Wrap/skip: ptr=14 (after serving 13), req=16'h0011 -> grant idx 0, then idx 4, then idx 0.
- Withdrawal and enable: granted idx 5; drop req[5] -> release next edge, ptr=6. Hold en=0 with req=16'h0100 -> no grant. Raise en -> gnt=16'h0100, gnt_idx=8.
- Owner stability: during grant to idx 3, toggle other req bits and en -> gnt stays 16'h0008 until done=1.
- With ARB_TIMEOUT_EN, MAX_HOLD=4: grant idx 2, done never asserted -> forced release after 4 GRANT cycles, timeout=1 for one cycle, next grant goes to the next pending index above 2.

Source files
------------

// File: rtl/arb_rr16.sv
// rtl/arb_rr16.sv - 16-requester round-robin arbiter with registered one-hot grant and index
// Optional forced release after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
module arb_rr16 #(
  parameter int MAX_HOLD = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_idx,
  output logic        gnt_valid,
  output logic        timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_nxt;
  logic [3:0] ptr, ptr_nxt;
  logic [3:0] idx, idx_nxt;
  logic [3:0] winner, cand;
  logic       found;
  logic       normal_rel, force_rel;

  if (MAX_HOLD < 1 || MAX_HOLD > 65535) begin : g_bad_hold
    $error("arb_rr16: MAX_HOLD out of range 1..65535");
  end

  // Scan starts at ptr so the most recently served requester is checked last.
  always_comb begin
    winner = 4'h0;
    cand   = 4'h0;
    found  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cand = ptr + 4'(i);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign normal_rel = (state == GRANT) && (done || !req[idx]);

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);

  logic [15:0] hold;
  logic        timeout_q;

  assign force_rel = (state == GRANT) && !normal_rel && (hold == HOLD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= 16'h0000;
      timeout_q <= 1'b0;
    end else begin
      hold      <= (state == GRANT) ? hold + 16'h0001 : 16'h0000;
      timeout_q <= force_rel;
    end
  end

  assign timeout = timeout_q;
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 4'h0;
      idx   <= 4'h0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (en && found) begin
          state_nxt = GRANT;
          idx_nxt   = winner;
        end
      end
      GRANT: begin
        if (normal_rel || force_rel) begin
          state_nxt = IDLE;
          idx_nxt   = 4'h0;
          ptr_nxt   = idx + 4'h1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt = 16'h0000;
    if (state == GRANT) gnt[idx] = 1'b1;
    gnt_idx   = idx;
    gnt_valid = (state == GRANT);
  end

endmodule

// File: tb/tb_arb_rr16.sv
// tb/tb_arb_rr16.sv - randomized and directed bench for arb_rr16 against a behavioural model
module tb_arb_rr16;

  localparam int MAX_HOLD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] req = 16'h0000;
  logic        done = 1'b0;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic        timeout;

  int checks = 0;
  int failures = 0;

  int m_owner = -1;
  int m_ptr = 0;
  int m_held = 0;
  bit m_to = 1'b0;

  arb_rr16 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_step();
    m_to = 1'b0;
    if (m_owner < 0) begin
      if (en && req != 16'h0000) begin
        for (int i = 0; i < 16; i++) begin
          if (m_owner < 0 && req[(m_ptr + i) % 16]) m_owner = (m_ptr + i) % 16;
        end
        m_held = 0;
      end
    end else begin
      m_held++;
      if (done || !req[m_owner]) begin
        m_ptr   = (m_owner + 1) % 16;
        m_owner = -1;
      end
`ifdef ARB_TIMEOUT_EN
      else if (m_held == MAX_HOLD) begin
        m_ptr   = (m_owner + 1) % 16;
        m_owner = -1;
        m_to    = 1'b1;
      end
`endif
    end
  endtask

  task automatic compare_all();
    check("gnt", 32'(gnt), (m_owner < 0) ? 32'h0 : (32'h1 << m_owner));
    check("gnt_idx", 32'(gnt_idx), (m_owner < 0) ? 32'h0 : 32'(m_owner));
    check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    check("timeout", 32'(timeout), 32'(m_to));
  endtask

  task automatic cycle(input logic e, input logic [15:0] r, input logic d);
    en   = e;
    req  = r;
    done = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [15:0] r;
    // reset with all requests pending
    rst = 1'b1; en = 1'b1; req = 16'hFFFF;
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_idx", 32'(gnt_idx), 32'h0);
    check("rst_valid", 32'(gnt_valid), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    cycle(1'b1, 16'hFFFF, 1'b0);
    check("first_gnt", 32'(gnt), 32'h0001);
    check("first_idx", 32'(gnt_idx), 32'h0);

    // round robin over all sixteen, one idle cycle between grants
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 16'hFFFF, 1'b1);
      check("rr_gap", 32'(gnt_valid), 32'h0);
      cycle(1'b1, 16'hFFFF, 1'b0);
      check("rr_idx", 32'(gnt_idx), 32'(i % 16));
    end
    cycle(1'b1, 16'hFFFF, 1'b1);

    // wrap/skip: serve 13 so ptr=14, then 0x0011
    cycle(1'b1, 16'h2000, 1'b0);
    check("serve13", 32'(gnt_idx), 32'd13);
    cycle(1'b1, 16'h2000, 1'b1);
    cycle(1'b1, 16'h0011, 1'b0);
    check("wrap_0", 32'(gnt_idx), 32'd0);
    cycle(1'b1, 16'h0011, 1'b1);
    cycle(1'b1, 16'h0011, 1'b0);
    check("wrap_4", 32'(gnt_idx), 32'd4);
    cycle(1'b1, 16'h0011, 1'b1);
    cycle(1'b1, 16'h0011, 1'b0);
    check("wrap_0b", 32'(gnt_idx), 32'd0);
    cycle(1'b1, 16'h0011, 1'b1);

    // withdrawal and enable
    cycle(1'b1, 16'h0020, 1'b0);
    check("wd_grant5", 32'(gnt_idx), 32'd5);
    cycle(1'b1, 16'h0000, 1'b0);
    check("wd_release", 32'(gnt_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 16'h0100, 1'b0);
      check("en_block", 32'(gnt_valid), 32'h0);
    end
    cycle(1'b1, 16'h0100, 1'b0);
    check("en_gnt", 32'(gnt), 32'h0100);
    check("en_idx", 32'(gnt_idx), 32'd8);
    cycle(1'b1, 16'h0100, 1'b1);

    // owner stability while other bits and en toggle
    cycle(1'b1, 16'h0008, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'($urandom), 16'($urandom) | 16'h0008, 1'b0);
      check("own_stable", 32'(gnt), 32'h0008);
    end
    cycle(1'b1, 16'h0008, 1'b1);
    check("own_release", 32'(gnt_valid), 32'h0);

`ifdef ARB_TIMEOUT_EN
    // serve 1 so ptr=2, then hold 2 without done
    cycle(1'b1, 16'h0002, 1'b0);
    cycle(1'b1, 16'h0002, 1'b1);
    cycle(1'b1, 16'h0024, 1'b0);
    check("to_grant2", 32'(gnt_idx), 32'd2);
    for (int i = 0; i < MAX_HOLD - 1; i++) begin
      cycle(1'b1, 16'h0024, 1'b0);
      check("to_hold", 32'(gnt_valid), 32'h1);
    end
    cycle(1'b1, 16'h0024, 1'b0);
    check("to_release", 32'(gnt_valid), 32'h0);
    check("to_pulse", 32'(timeout), 32'h1);
    cycle(1'b1, 16'h0024, 1'b0);
    check("to_next5", 32'(gnt_idx), 32'd5);
    check("to_clear", 32'(timeout), 32'h0);
    cycle(1'b1, 16'h0024, 1'b1);
`endif

    // asynchronous reset mid-grant
    cycle(1'b1, 16'h0400, 1'b0);
    check("pre_async", 32'(gnt_valid), 32'h1);
    rst = 1'b1;
    #1;
    check("async_gnt", 32'(gnt), 32'h0);
    check("async_valid", 32'(gnt_valid), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r = 16'($urandom);
      if ($urandom_range(0, 3) != 0) r = r & 16'($urandom) & 16'($urandom);
      cycle($urandom_range(0, 4) != 0, r, $urandom_range(0, 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
